// File: rtl/arb_mux_pkg.sv
// Shared constants and types for the round-robin 4:1 arbitrated mux.
package arb_mux_pkg;
  localparam int N_REQ = 4;
  typedef logic [1:0] req_idx_t;
endpackage

// File: rtl/rr_arbiter_4.sv
// Combinational round-robin arbiter: first set req bit from ptr upward, wrapping.
module rr_arbiter_4
  import arb_mux_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  req_idx_t         ptr,
  output logic [N_REQ-1:0] grant,
  output req_idx_t         grant_idx,
  output logic             any
);
  req_idx_t idx;
  logic     found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    any       = |req;
    // 2-bit index arithmetic wraps 3 -> 0 for free
    for (int k = 0; k < N_REQ; k++) begin
      idx = ptr + req_idx_t'(k);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant_idx  = idx;
        grant[idx] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/arb_mux_4.sv
// Four requesters time-share one registered output slot under round-robin arbitration.
module arb_mux_4
  import arb_mux_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] in_valid,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  output logic [N_REQ-1:0] in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_sel,
  input  logic             out_ready
);
  logic [N_REQ-1:0][WIDTH-1:0] din;
  logic [N_REQ-1:0]            grant;
  req_idx_t                    grant_idx;
  req_idx_t                    ptr;
  logic                        any;
  logic                        load;

  assign din  = {d3, d2, d1, d0};
  assign load = !out_valid || out_ready;

  rr_arbiter_4 u_arb (
    .req       (in_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any)
  );

  // No handshake may complete while reset is held
  assign in_ready = (load && !rst) ? grant : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (load) begin
      if (any) begin
        out_valid <= 1'b1;
        out_data  <= din[grant_idx];
        out_sel   <= grant_idx;
        ptr       <= grant_idx + req_idx_t'(1);
      end else begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: doc/arb_mux_4.md
ARB_MUX_4 -- requirements
Module: arb_mux_4

Interface
REQ-001 Parameter: WIDTH, default 4, data width of every input and output data port.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 in_valid  input  4  bit i = requester i has data on d<i>.
REQ-005 d0, d1, d2, d3  input  WIDTH each  requester data, held stable while in_valid[i]=1 and in_ready[i]=0.
REQ-006 in_ready  output  4  one-hot or zero; bit i = d<i> captured this cycle.
REQ-007 out_valid  output  1  output register holds a valid item.
REQ-008 out_data  output  WIDTH  registered data of the granted requester.
REQ-009 out_sel  output  2  registered index of the requester whose data is in out_data.
REQ-010 out_ready  input  1  downstream accepts the item when out_valid=1 and out_ready=1.

Function
REQ-011 The block SHALL time-share one 4:1 data path between 4 requesters using round-robin arbitration.
REQ-012 load = !out_valid || out_ready; capture occurs only when load=1 and at least one in_valid bit is 1.
REQ-013 Grant SHALL be the first set in_valid bit searching from index ptr upward, wrapping 3 -> 0.
REQ-014 in_ready[g] SHALL be 1 combinationally in the capture cycle for granted index g only; all other bits 0; in_ready SHALL be 4'b0000 when load=0.
REQ-015 On capture: out_data <= d<g>, out_sel <= g, out_valid <= 1, ptr <= (g+1) mod 4.
REQ-016 When load=1 and in_valid=0: out_valid <= 0; out_data, out_sel and ptr hold.
REQ-017 When load=0 (out_valid=1, out_ready=0): out_valid, out_data, out_sel, ptr SHALL hold unchanged.
REQ-018 Latency: item captured in cycle N appears on out_* in cycle N+1; throughput one item per cycle with out_ready held 1.
REQ-019 Simultaneous out_ready=1 and new capture in same cycle SHALL replace the output item without a bubble.
REQ-020 ptr SHALL advance only on capture; a requester never wins twice in a row while another requester is valid.
REQ-021 Each requester with in_valid held 1 SHALL be granted within 4 captures (starvation-free).

Reset
REQ-022 While rst=1: out_valid=0, out_data=0, out_sel=0, ptr=0, in_ready=4'b0000 (combinationally forced).
REQ-023 rst asserted mid-transfer SHALL discard the held item; no handshake completes in a reset cycle.
REQ-024 First cycle after rst deasserts SHALL arbitrate from ptr=0.

Structure
REQ-025 Package arb_mux_pkg SHALL hold N_REQ=4 and the 2-bit requester index typedef used by ptr, grant and out_sel.
REQ-026 Round-robin grant logic SHALL be one combinational sub-module rr_arbiter_4 (inputs req[3:0], ptr; outputs grant one-hot, grant_idx, any).
REQ-027 Data selection SHALL use grant_idx as a 4:1 mux select; output register and ptr live in arb_mux_4.

Verification
REQ-028 Reset: rst=1 two cycles with in_valid=4'b1111 -> in_ready=0000, out_valid=0, out_data=0, out_sel=0.
REQ-029 All requesting, out_ready=1, d0..d3 = 4'h1,4'h2,4'h3,4'h4 -> out_sel sequence 0,1,2,3,0 on consecutive cycles, out_data 1,2,3,4,1.
REQ-030 Backpressure: capture d2=4'hA, then out_ready=0 for 3 cycles with in_valid=1111 -> out_data=4'hA, out_sel=2, in_ready=0000 held; first out_ready=1 cycle grants index 3.
REQ-031 Sparse/wrap: ptr=3, in_valid=4'b0010 -> grant 1, ptr becomes 2; then in_valid=4'b0001 -> grant 0.
REQ-032 Idle drain: single capture then in_valid=0 with out_ready=1 -> out_valid 1 for one cycle, then 0; out_data holds.
REQ-033 Reset mid-stall: out_valid=1, out_ready=0, assert rst one cycle -> out_valid=0, next arbitration starts at index 0.
